// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 configuration arbiter: FSM state
// encoding and the codec register addresses used by the requesters.
package wm8731_pkg;

    typedef enum logic [2:0] {
        s_WAIT_INIT = 3'd0,
        s_IDLE      = 3'd1,
        s_ISSUE     = 3'd2,
        s_WAIT_BUSY = 3'd3,
        s_WAIT_DONE = 3'd4,
        s_ACK       = 3'd5
    } state_e;

    localparam logic [6:0] LINVOL   = 7'h00;
    localparam logic [6:0] RINVOL   = 7'h01;
    localparam logic [6:0] LHPOUT   = 7'h02;
    localparam logic [6:0] RHPOUT   = 7'h03;
    localparam logic [6:0] DIGITAL  = 7'h05;
    localparam logic [6:0] SAMPLING = 7'h08;
    localparam logic [6:0] ACTIVE   = 7'h09;

endpackage

// File: rtl/wm8731_cfg_arb_rr_arbiter.sv
// Combinational round-robin pick: searches req_i starting at ptr_i and
// wrapping, returns the first set requester.
//   req_i     - request vector
//   ptr_i     - index with highest priority this round
//   valid_c_o - any request set
//   idx_c_o   - winning requester index
module rr_arbiter #(
    parameter  int unsigned p_NUM_REQ = 4,
    localparam int unsigned IDX_W     = $clog2(p_NUM_REQ)
) (
    input  logic [p_NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 valid_c_o,
    output logic [IDX_W-1:0]     idx_c_o
);

    // First requester found in order ptr, ptr+1, ... wins.
    always_comb begin
        valid_c_o = 1'b0;
        idx_c_o   = '0;
        for (int unsigned i = 0; i < p_NUM_REQ; i++) begin
            if (!valid_c_o && req_i[IDX_W'((32'(ptr_i) + i) % p_NUM_REQ)]) begin
                valid_c_o = 1'b1;
                idx_c_o   = IDX_W'((32'(ptr_i) + i) % p_NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/wm8731_cfg_arb.sv
// Round-robin arbiter sharing the WM8731 register-write port among
// p_NUM_REQ requesters; waits for the writer's power-up init first and
// aborts a write that exceeds p_TIMEOUT cycles.
//   i_clk, i_rstn          - clock, synchronous active-low reset
//   i_req/i_addr/i_data    - per-requester level request and payload
//   o_ack, o_timeout       - end-of-write pulse to the winner, abort flag
//   o_reg_addr/o_reg_data  - payload held for the register writer
//   o_start, i_wr_done     - writer handshake
//   o_busy                 - high outside s_IDLE
module wm8731_cfg_arb
    import wm8731_pkg::*;
#(
    parameter int unsigned p_NUM_REQ = 4,
    parameter int unsigned p_TIMEOUT = 2000000
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [p_NUM_REQ-1:0]   i_req,
    input  logic [p_NUM_REQ*7-1:0] i_addr,
    input  logic [p_NUM_REQ*9-1:0] i_data,
    output logic [p_NUM_REQ-1:0]   o_ack,
    output logic                   o_timeout,
    output logic [6:0]             o_reg_addr,
    output logic [8:0]             o_reg_data,
    output logic                   o_start,
    input  logic                   i_wr_done,
    output logic                   o_busy
);

    localparam int unsigned IDX_W = $clog2(p_NUM_REQ);
    localparam int unsigned CNT_W = $clog2(p_TIMEOUT);

    state_e               state_q,   state_d;
    logic [IDX_W-1:0]     ptr_q,     ptr_d;
    logic [IDX_W-1:0]     win_q,     win_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [6:0]           addr_q,    addr_d;
    logic [8:0]           data_q,    data_d;
    logic                 start_q,   start_d;
    logic [p_NUM_REQ-1:0] ack_q,     ack_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q,    busy_d;

    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;

    rr_arbiter #(.p_NUM_REQ(p_NUM_REQ)) u_rr (
        .req_i     (i_req),
        .ptr_i     (ptr_q),
        .valid_c_o (grant_valid),
        .idx_c_o   (grant_idx)
    );

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= s_WAIT_INIT;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            start_q   <= 1'b0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            start_q   <= start_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    // Next state; pulse outputs are set on the transition into the state
    // in which they must be visible.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        start_d   = 1'b0;
        ack_d     = '0;
        timeout_d = 1'b0;

        case (state_q)
            s_WAIT_INIT: begin
                if (i_wr_done) state_d = s_IDLE;
            end
            s_IDLE: begin
                if (grant_valid && i_wr_done) begin
                    win_d   = grant_idx;
                    addr_d  = 7'(i_addr >> (7 * 32'(grant_idx)));
                    data_d  = 9'(i_data >> (9 * 32'(grant_idx)));
                    cnt_d   = '0;
                    start_d = 1'b1;
                    state_d = s_ISSUE;
                end
            end
            s_ISSUE: begin
                state_d = s_WAIT_BUSY;
            end
            s_WAIT_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // Writer drops done to acknowledge the start.
                if (!i_wr_done) begin
                    state_d = s_WAIT_DONE;
                end else if (cnt_q == CNT_W'(p_TIMEOUT - 1)) begin
                    state_d      = s_ACK;
                    ack_d[win_q] = 1'b1;
                    timeout_d    = 1'b1;
                end
            end
            s_WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (i_wr_done) begin
                    state_d      = s_ACK;
                    ack_d[win_q] = 1'b1;
                end else if (cnt_q == CNT_W'(p_TIMEOUT - 1)) begin
                    state_d      = s_ACK;
                    ack_d[win_q] = 1'b1;
                    timeout_d    = 1'b1;
                end
            end
            s_ACK: begin
                // Served requester drops to lowest priority.
                ptr_d   = (win_q == IDX_W'(p_NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d = s_IDLE;
            end
            default: begin
                state_d = s_WAIT_INIT;
            end
        endcase

        busy_d = (state_d != s_IDLE);
    end

    assign o_ack      = ack_q;
    assign o_timeout  = timeout_q;
    assign o_reg_addr = addr_q;
    assign o_reg_data = data_q;
    assign o_start    = start_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_wm8731_cfg_arb.sv
// Bench for wm8731_cfg_arb: directed table, hand sequences for reset,
// mid-write requests, timeout and reset mid-write, then random traffic
// checked against a transaction-level round-robin model.
module tb_wm8731_cfg_arb;

    localparam int N  = 4;
    localparam int TO = 64;

    logic           i_clk = 1'b0;
    logic           i_rstn;
    logic [N-1:0]   i_req;
    logic [N*7-1:0] i_addr;
    logic [N*9-1:0] i_data;
    logic           i_wr_done;
    logic [N-1:0]   o_ack;
    logic           o_timeout;
    logic [6:0]     o_reg_addr;
    logic [8:0]     o_reg_data;
    logic           o_start;
    logic           o_busy;

    wm8731_cfg_arb #(.p_NUM_REQ(N), .p_TIMEOUT(TO)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_timeout  (o_timeout),
        .o_reg_addr (o_reg_addr),
        .o_reg_data (o_reg_data),
        .o_start    (o_start),
        .i_wr_done  (i_wr_done),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    // Writer model state
    int wr_phase  = 0;
    int wr_cd     = 0;
    bit wr_ignore = 1'b0;
    int wr_drop   = 0;
    int wr_len    = 10;
    int rise_cyc  = -100;

    logic [N-1:0] req_prev;
    int start_cyc, ack_cyc;
    logic [N-1:0] ack_v;
    logic to_v;

    typedef struct {
        logic [N-1:0] req;
        int           exp;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Register writer: drops done wr_drop cycles after start, holds low wr_len cycles.
    task automatic writer_update();
        if (wr_phase == 0 && o_start === 1'b1 && !wr_ignore) begin
            wr_phase = 1;
            wr_cd    = wr_drop;
        end
        if (wr_phase == 1) begin
            if (wr_cd == 0) begin
                i_wr_done = 1'b0;
                wr_phase  = 2;
                wr_cd     = wr_len;
            end else wr_cd--;
        end else if (wr_phase == 2) begin
            if (wr_cd == 0) begin
                i_wr_done = 1'b1;
                wr_phase  = 0;
                rise_cyc  = cyc;
            end else wr_cd--;
        end
    endtask

    task automatic step();
        req_prev = i_req;
        @(posedge i_clk);
        #1;
        cyc++;
        writer_update();
    endtask

    task automatic wait_start(input int budget, output bit got);
        int i;
        got = 1'b0;
        i   = 0;
        while (!got && i < budget) begin
            step();
            i++;
            if (o_start === 1'b1) begin
                got       = 1'b1;
                start_cyc = cyc;
            end
        end
    endtask

    task automatic wait_ack(input int budget, output bit got);
        int i;
        got = 1'b0;
        i   = 0;
        while (!got && i < budget) begin
            step();
            i++;
            if (o_ack !== '0) begin
                got     = 1'b1;
                ack_cyc = cyc;
                ack_v   = o_ack;
                to_v    = o_timeout;
            end
        end
    endtask

    task automatic set_defaults();
        i_addr = {7'h09, 7'h02, 7'h05, 7'h00};
        i_data = {9'h001, 9'h079, 9'h006, 9'h017};
    endtask

    // One complete write; expw is the requester that must win.
    task automatic run_txn(input logic [N-1:0] mask, input int expw, input string nm, input bit clear);
        bit got;
        i_req = mask;
        wait_start(400, got);
        chk({nm, " start seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, " addr"}, 32'(o_reg_addr), 32'(i_addr[7*expw +: 7]));
            chk({nm, " data"}, 32'(o_reg_data), 32'(i_data[9*expw +: 9]));
        end
        wait_ack(400, got);
        chk({nm, " ack seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, " ack vector"}, 32'(ack_v), 32'(1) << expw);
            chk({nm, " timeout flag"}, 32'(to_v), 32'd0);
            chk({nm, " ack latency"}, 32'(ack_cyc), 32'(rise_cyc + 1));
        end
        if (clear) i_req = '0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] t;
        for (int i = 0; i < N; i++) begin
            t = r >> ((p + i) % N);
            if (t[0]) return (p + i) % N;
        end
        return -1;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int cnt_a, cnt_b;
        int outstanding, mptr, w;

        tbl[0] = '{4'b1111, 3};
        tbl[1] = '{4'b0110, 1};
        tbl[2] = '{4'b0011, 0};
        tbl[3] = '{4'b1001, 3};
        tbl[4] = '{4'b1000, 3};
        tbl[5] = '{4'b0101, 0};
        tbl[6] = '{4'b0001, 0};
        tbl[7] = '{4'b1110, 1};
        tbl[8] = '{4'b1011, 3};

        // Reset and power-up init
        i_rstn = 1'b0; i_req = '0; i_wr_done = 1'b0;
        set_defaults();
        repeat (3) step();
        chk("reset busy", 32'(o_busy), 32'd1);
        chk("reset start", 32'(o_start), 32'd0);
        chk("reset ack", 32'(o_ack), 32'd0);
        chk("reset timeout", 32'(o_timeout), 32'd0);
        chk("reset reg addr", 32'(o_reg_addr), 32'd0);
        chk("reset reg data", 32'(o_reg_data), 32'd0);
        i_rstn = 1'b1;
        i_req  = 4'b0001;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (o_start === 1'b1) cnt_a++;
            if (o_busy !== 1'b1) cnt_b++;
        end
        chk("no start during init", 32'(cnt_a), 32'd0);
        chk("busy during init", 32'(cnt_b), 32'd0);
        i_req = '0;
        i_wr_done = 1'b1;
        step();
        chk("busy drops after init", 32'(o_busy), 32'd0);
        step();

        // Single request, 50-cycle write
        wr_drop = 0; wr_len = 50;
        run_txn(4'b0100, 2, "single", 1'b1);
        chk("single addr value", 32'(o_reg_addr), 32'h02);
        step();

        // Table of contention patterns
        for (int v = 0; v < 9; v++) begin
            wr_len  = 3 + v;
            wr_drop = v % 3;
            run_txn(tbl[v].req, tbl[v].exp, $sformatf("table%0d", v), 1'b1);
            step();
        end

        // Continuous full contention
        wr_drop = 0; wr_len = 4;
        run_txn(4'b1111, 0, "rr0", 1'b0);
        run_txn(4'b1111, 1, "rr1", 1'b0);
        run_txn(4'b1111, 2, "rr2", 1'b0);
        run_txn(4'b1111, 3, "rr3", 1'b0);
        run_txn(4'b1111, 0, "rr4", 1'b1);
        step();

        // Request arriving mid-write waits for the next arbitration
        wr_len = 20;
        i_req = 4'b1000;
        wait_start(100, got);
        chk("midreq start3", 32'(got), 32'd1);
        repeat (3) step();
        i_req = 4'b1010;
        wait_ack(200, got);
        chk("midreq ack3", 32'(ack_v), 32'b1000);
        i_req = 4'b0010;
        cnt_a = ack_cyc;
        wait_start(100, got);
        chk("midreq start1 latency", 32'(start_cyc), 32'(cnt_a + 2));
        chk("midreq addr1", 32'(o_reg_addr), 32'h05);
        wait_ack(200, got);
        chk("midreq ack1", 32'(ack_v), 32'b0010);
        i_req = '0;
        step();

        // Timeout: writer never acknowledges
        wr_ignore = 1'b1;
        i_req = 4'b0001;
        wait_start(100, got);
        wait_ack(TO + 20, got);
        chk("timeout ack seen", 32'(got), 32'd1);
        chk("timeout ack cycle", 32'(ack_cyc), 32'(start_cyc + TO + 1));
        chk("timeout ack vector", 32'(ack_v), 32'b0001);
        chk("timeout flag", 32'(to_v), 32'd1);
        i_req = '0;
        step();
        chk("timeout pulse width", 32'({o_ack, o_timeout}), 32'd0);
        wr_ignore = 1'b0;
        run_txn(4'b0011, 1, "ptr after timeout", 1'b1);
        step();

        // Reset in the middle of a write
        wr_len = 50;
        i_req = 4'b0100;
        wait_start(100, got);
        repeat (4) step();
        i_rstn = 1'b0; wr_phase = 0; i_wr_done = 1'b0; i_req = '0;
        cnt_a = 0;
        repeat (2) begin step(); if (o_ack !== '0) cnt_a++; end
        chk("midreset busy", 32'(o_busy), 32'd1);
        chk("midreset start", 32'(o_start), 32'd0);
        i_rstn = 1'b1;
        i_req = 4'b1111;
        cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_ack !== '0) cnt_a++;
            if (o_start === 1'b1) cnt_b++;
        end
        chk("midreset no ack", 32'(cnt_a), 32'd0);
        chk("midreset waits init", 32'(cnt_b), 32'd0);
        i_req = '0;
        i_wr_done = 1'b1;
        step();
        chk("midreset idle", 32'(o_busy), 32'd0);
        wr_len = 5;
        run_txn(4'b1111, 0, "ptr after reset", 1'b1);
        repeat (2) step();

        // Random traffic against the transaction-level model
        mptr = 1; outstanding = -1;
        for (int t = 0; t < 2300; t++) begin
            if (t < 2000) begin
                for (int k = 0; k < N; k++) begin
                    if (!i_req[k] && $urandom_range(0, 7) == 0) begin
                        i_addr[7*k +: 7] = 7'($urandom);
                        i_data[9*k +: 9] = 9'($urandom);
                        i_req[k] = 1'b1;
                    end
                end
            end
            step();
            if (o_start === 1'b1) begin
                w = rr_pick(req_prev, mptr);
                chk("rand start while idle", 32'(outstanding), 32'hFFFF_FFFF);
                chk("rand winner exists", 32'(w >= 0), 32'd1);
                if (w >= 0) begin
                    chk("rand addr", 32'(o_reg_addr), 32'(i_addr[7*w +: 7]));
                    chk("rand data", 32'(o_reg_data), 32'(i_data[9*w +: 9]));
                end
                outstanding = w;
                wr_drop = $urandom_range(0, 2);
                wr_len  = $urandom_range(1, 20);
            end
            if (o_ack !== '0) begin
                chk("rand ack expected", 32'(outstanding >= 0), 32'd1);
                if (outstanding >= 0) begin
                    chk("rand ack vector", 32'(o_ack), 32'(1) << outstanding);
                    chk("rand ack latency", 32'(cyc), 32'(rise_cyc + 1));
                    chk("rand timeout flag", 32'(o_timeout), 32'd0);
                    i_req[outstanding] = 1'b0;
                    mptr = (outstanding + 1) % N;
                end
                outstanding = -1;
            end
        end
        chk("rand drained", 32'(i_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
